// File: rtl/br_inject_arbiter_pkg.sv
// Shared BrLite types for the local injection arbiter.
//   BR_ID_W        : default packet id width stamped into each flit
//   br_svc_t       : flit service class
//   br_data_t      : flit carried on the PE local injection port
//   br_inj_state_t : injection FSM state encoding
package br_inject_arbiter_pkg;

   localparam int BR_ID_W = 5;

   typedef enum logic [1:0] {
      SVC_DATA,
      SVC_CFG,
      SVC_IRQ,
      SVC_DBG
   } br_svc_t;

   typedef struct packed {
      br_svc_t              svc;
      logic [BR_ID_W-1:0]   id;
      logic [15:0]          payload;
   } br_data_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_RELEASE
   } br_inj_state_t;

endpackage

// File: rtl/br_inject_arbiter_if.sv
// Handshake bundle between local requesters, the injection arbiter and the
// router local port.
//   req_i/flit_i/ack_o : requester side (level request, one-cycle ack pulse)
//   busy_i             : router local port busy, blocks new injections
//   req_o/flit_o/ack_i : router side (registered request/flit, level ack)
//   grant_o            : one-hot owner of the in-flight injection
//   inj_cnt_o          : completed injection count
// master = requesters + router (bench), slave = arbiter.
interface br_inject_arbiter_if
   import br_inject_arbiter_pkg::*;
#(
   parameter int REQ_CNT = 4
);
   logic [REQ_CNT-1:0]              req_i;
   br_data_t [REQ_CNT-1:0]          flit_i;
   logic [REQ_CNT-1:0]              ack_o;
   logic                            busy_i;
   br_data_t                        flit_o;
   logic                            req_o;
   logic                            ack_i;
   logic [REQ_CNT-1:0]              grant_o;
   logic [15:0]                     inj_cnt_o;

   modport master (
      output req_i, flit_i, busy_i, ack_i,
      input  ack_o, flit_o, req_o, grant_o, inj_cnt_o
   );

   modport slave (
      input  req_i, flit_i, busy_i, ack_i,
      output ack_o, flit_o, req_o, grant_o, inj_cnt_o
   );
endinterface

// File: rtl/br_rr_picker.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : index of the last granted requester (lowest priority this round)
//   gnt : one-hot grant, zero when no request
module br_rr_picker #(
   parameter int REQ_CNT = 4
) (
   input  logic [REQ_CNT-1:0]         req,
   input  logic [$clog2(REQ_CNT)-1:0] ptr,
   output logic [REQ_CNT-1:0]         gnt
);
   localparam int PTR_W = $clog2(REQ_CNT);

   logic found;

   // Scan starting one past the pointer and wrapping; first hit wins.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int i = 1; i <= REQ_CNT; i++) begin
         if (!found && req[PTR_W'((int'(ptr) + i) % REQ_CNT)]) begin
            gnt[PTR_W'((int'(ptr) + i) % REQ_CNT)] = 1'b1;
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/br_inject_arbiter.sv
// Round-robin arbiter sharing one PE local injection port among REQ_CNT
// local requesters. Stamps a wrapping packet id into every injected flit.
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : requester/router handshake bundle (slave side)
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | no transfer; pick a requester when any req and !busy
// ST_SEND    | req_o/flit_o held until the router acks
// ST_RELEASE | req_o low, waiting for the router to drop ack_i
//
// ID_W must not exceed BR_ID_W (the flit id field width).
module br_inject_arbiter
   import br_inject_arbiter_pkg::*;
#(
   parameter int REQ_CNT = 4,
   parameter int ID_W    = BR_ID_W
) (
   input  logic               clk_i,
   input  logic               rst_i,
   br_inject_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(REQ_CNT);

   br_inj_state_t      state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [ID_W-1:0]    id_cnt;
   logic [REQ_CNT-1:0] pick_gnt;
   logic [PTR_W-1:0]   pick_idx;
   logic [PTR_W-1:0]   own_idx;
   br_data_t           pick_flit;

   br_rr_picker #(.REQ_CNT(REQ_CNT)) u_picker (
      .req (bus.req_i),
      .ptr (rr_ptr),
      .gnt (pick_gnt)
   );

   always_comb begin
      pick_idx = '0;
      own_idx  = '0;
      for (int i = 0; i < REQ_CNT; i++) begin
         if (pick_gnt[i])    pick_idx = PTR_W'(i);
         if (bus.grant_o[i]) own_idx  = PTR_W'(i);
      end
      pick_flit    = bus.flit_i[pick_idx];
      pick_flit.id = BR_ID_W'(id_cnt);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= ST_IDLE;
         rr_ptr        <= PTR_W'(REQ_CNT - 1);
         id_cnt        <= '0;
         bus.req_o     <= 1'b0;
         bus.ack_o     <= '0;
         bus.grant_o   <= '0;
         bus.flit_o    <= '0;
         bus.inj_cnt_o <= '0;
      end else begin
         bus.ack_o <= '0;
         case (state)
            ST_IDLE: begin
               if ((|bus.req_i) && !bus.busy_i) begin
                  bus.grant_o <= pick_gnt;
                  bus.flit_o  <= pick_flit;
                  bus.req_o   <= 1'b1;
                  state       <= ST_SEND;
               end
            end
            ST_SEND: begin
               // Owner is taken from grant_o, not req_i, so a requester
               // that drops mid-transfer still gets its ack.
               if (bus.ack_i) begin
                  bus.req_o     <= 1'b0;
                  bus.ack_o     <= bus.grant_o;
                  id_cnt        <= id_cnt + ID_W'(1);
                  bus.inj_cnt_o <= bus.inj_cnt_o + 16'd1;
                  rr_ptr        <= own_idx;
                  state         <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (!bus.ack_i) begin
                  bus.grant_o <= '0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_br_inject_arbiter.sv
// Directed bench for br_inject_arbiter with a hand-driven router model.
module tb_br_inject_arbiter;
   import br_inject_arbiter_pkg::*;

   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_err;

   br_inject_arbiter_if #(.REQ_CNT(4)) bus ();

   br_inject_arbiter #(.REQ_CNT(4), .ID_W(5)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      bus.req_i  = '0;
      bus.ack_i  = 1'b0;
      bus.busy_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_req(output int t);
      int n;
      n = 0;
      while (bus.req_o !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("req_wait", 32'(bus.req_o), 32'd1);
      t = cyc;
   endtask

   // Router: waits for req_o, returns ack_i after dly extra cycles, checks ack_o.
   task automatic serve(input int dly, output logic [3:0] g, output logic [4:0] id, output int t);
      wait_req(t);
      g  = bus.grant_o;
      id = bus.flit_o.id;
      repeat (dly) begin
         @(posedge clk);
         #1;
      end
      bus.ack_i = 1'b1;
      @(posedge clk);
      #1;
      chk("ack_o", 32'(bus.ack_o), 32'(g));
      chk("req_o_drop", 32'(bus.req_o), 32'd0);
      bus.ack_i = 1'b0;
   endtask

   logic [3:0] g;
   logic [4:0] id;
   int         t;
   int         t_prev;
   logic [3:0] exp_g [5];

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int k = 0; k < 4; k++) begin
         bus.flit_i[k].svc     = SVC_DATA;
         bus.flit_i[k].id      = 5'h1F;
         bus.flit_i[k].payload = 16'h0010 + 16'(k);
      end

      // single requester, ack 2 cycles after req_o
      do_reset();
      chk("rst_req_o", 32'(bus.req_o), 32'd0);
      chk("rst_grant", 32'(bus.grant_o), 32'd0);
      chk("rst_ack_o", 32'(bus.ack_o), 32'd0);
      chk("rst_inj_cnt", 32'(bus.inj_cnt_o), 32'd0);
      chk("rst_flit", 32'(bus.flit_o), 32'd0);
      bus.flit_i[0].payload = 16'h00AB;
      bus.req_i = 4'b0001;
      @(posedge clk);
      #1;
      chk("t1_req_lat", 32'(bus.req_o), 32'd1);
      chk("t1_grant", 32'(bus.grant_o), 32'h1);
      chk("t1_id", 32'(bus.flit_o.id), 32'd0);
      chk("t1_payload", 32'(bus.flit_o.payload), 32'hAB);
      @(posedge clk);
      #1;
      chk("t1_req_hold", 32'(bus.req_o), 32'd1);
      bus.ack_i = 1'b1;
      @(posedge clk);
      #1;
      chk("t1_ack_o", 32'(bus.ack_o), 32'h1);
      chk("t1_req_low", 32'(bus.req_o), 32'd0);
      chk("t1_inj_cnt", 32'(bus.inj_cnt_o), 32'd1);
      bus.ack_i = 1'b0;
      bus.req_i = 4'b0000;
      @(posedge clk);
      #1;
      chk("t1_ack_pulse", 32'(bus.ack_o), 32'd0);
      chk("t1_grant_clr", 32'(bus.grant_o), 32'd0);

      // contention, all four requesting
      exp_g[0] = 4'b0001;
      exp_g[1] = 4'b0010;
      exp_g[2] = 4'b0100;
      exp_g[3] = 4'b1000;
      exp_g[4] = 4'b0001;
      do_reset();
      bus.req_i = 4'b1111;
      t_prev = 0;
      for (int i = 0; i < 5; i++) begin
         serve(0, g, id, t);
         chk("rr_grant", 32'(g), 32'(exp_g[i]));
         chk("rr_id", 32'(id), 32'(i));
         if (i > 0) chk("rr_spacing", 32'(t - t_prev), 32'd3);
         t_prev = t;
      end
      bus.req_i = 4'b0000;
      @(posedge clk);
      #1;

      // busy holds off injection
      do_reset();
      bus.busy_i = 1'b1;
      bus.req_i  = 4'b0100;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("busy_no_req", 32'({bus.req_o, bus.grant_o}), 32'd0);
      end
      bus.busy_i = 1'b0;
      @(posedge clk);
      #1;
      chk("busy_req_lat", 32'(bus.req_o), 32'd1);
      chk("busy_grant", 32'(bus.grant_o), 32'b0100);
      serve(1, g, id, t);
      bus.req_i = 4'b0000;
      @(posedge clk);
      #1;

      // id wrap over 33 injections
      do_reset();
      bus.req_i = 4'b0001;
      for (int i = 0; i < 33; i++) begin
         serve(0, g, id, t);
         chk("wrap_id", 32'(id), 32'(i % 32));
      end
      chk("wrap_inj_cnt", 32'(bus.inj_cnt_o), 32'd33);

      // reset while requester 1 is in SEND
      bus.req_i = 4'b0011;
      wait_req(t);
      chk("mid_grant", 32'(bus.grant_o), 32'b0010);
      #3;
      rst = 1'b1;
      #1;
      chk("mid_rst_req", 32'(bus.req_o), 32'd0);
      chk("mid_rst_grant", 32'(bus.grant_o), 32'd0);
      chk("mid_rst_inj", 32'(bus.inj_cnt_o), 32'd0);
      bus.ack_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_rst_ack", 32'(bus.ack_o), 32'd0);
      bus.ack_i = 1'b0;
      rst = 1'b0;
      serve(0, g, id, t);
      chk("post_rst_grant", 32'(g), 32'b0001);
      chk("post_rst_id", 32'(id), 32'd0);
      bus.req_i = 4'b0000;
      @(posedge clk);
      #1;

      // requester drops req one cycle into SEND; ack_i held long in RELEASE
      do_reset();
      bus.flit_i[3].payload = 16'h005C;
      bus.req_i = 4'b1000;
      wait_req(t);
      chk("drop_grant", 32'(bus.grant_o), 32'b1000);
      @(posedge clk);
      #1;
      bus.req_i = 4'b0000;
      bus.flit_i[3].payload = 16'h0000;
      @(posedge clk);
      #1;
      chk("drop_req_hold", 32'(bus.req_o), 32'd1);
      chk("drop_payload", 32'(bus.flit_o.payload), 32'h5C);
      bus.ack_i = 1'b1;
      @(posedge clk);
      #1;
      chk("drop_ack_o", 32'(bus.ack_o), 32'b1000);
      chk("drop_inj_cnt", 32'(bus.inj_cnt_o), 32'd1);
      @(posedge clk);
      #1;
      chk("rel_hold_grant", 32'(bus.grant_o), 32'b1000);
      chk("rel_no_reack", 32'(bus.ack_o), 32'd0);
      bus.ack_i = 1'b0;
      @(posedge clk);
      #1;
      chk("rel_grant_clr", 32'(bus.grant_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/br_inject_arbiter.md
BR_INJECT_ARBITER -- requirements
Module: br_inject_arbiter

Interface
REQ-001 Parameter REQ_CNT, default 4: number of local requesters sharing one PE local injection port; legal range 2..8.
REQ-002 Parameter ID_W, default 5: width of the packet id stamped into each flit.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 req_i  input  REQ_CNT  per-requester injection request; level, held until matching ack_o.
REQ-006 flit_i  input  REQ_CNT x br_data_t  per-requester flit; id field ignored.
REQ-007 ack_o  output  REQ_CNT  per-requester acceptance; one-cycle pulse.
REQ-008 busy_i  input  1  router local port busy; no new injection starts while high.
REQ-009 flit_o  output  br_data_t  flit to router local port, registered.
REQ-010 req_o  output  1  request to router local port, registered.
REQ-011 ack_i  input  1  router acceptance, level.
REQ-012 grant_o  output  REQ_CNT  one-hot owner of the in-flight injection; zero when idle.
REQ-013 inj_cnt_o  output  16  count of completed injections; wraps 0xFFFF->0.

Function
REQ-014 The FSM SHALL have three states: IDLE, SEND and RELEASE.
REQ-015 IDLE, with any req_i high and busy_i low, SHALL transition to SEND.
- Round-robin pick starts at the index after the last granted one.
- Latches flit_i[k] into flit_o, with id overwritten by id counter.
- Sets grant_o[k] and req_o high on the next edge: one cycle from request to req_o.
REQ-016 IDLE with busy_i high SHALL hold; no grant, req_o low, pointer unchanged.
REQ-017 SEND SHALL hold req_o and flit_o stable until ack_i is sampled high.
- Then: req_o low, ack_o[k] pulsed one cycle, id counter +1, inj_cnt_o +1, round-robin pointer set to k.
- Transition to RELEASE.
REQ-018 RELEASE SHALL keep req_o low and wait for ack_i low.
- Then: grant_o cleared, transition to IDLE.
- ack_i already low on entry still costs one cycle in RELEASE.
REQ-019 The id counter SHALL be ID_W bits and wrap from 2^ID_W-1 to 0.
REQ-020 A requester dropping req_i during SEND SHALL NOT abort the injection; the latched flit completes and ack_o is still pulsed.
REQ-021 busy_i rising during SEND or RELEASE SHALL NOT affect the in-flight transfer.
REQ-022 After reset the round-robin pointer SHALL be REQ_CNT-1, so index 0 wins the first simultaneous contention.
REQ-023 At most one ack_o bit SHALL be high in any cycle, and only on the cycle after ack_i is sampled high in SEND.
REQ-024 Minimum cadence SHALL be 3 cycles per injection (IDLE, SEND, RELEASE) with a one-cycle-ack router.

Reset
REQ-025 rst_i high SHALL asynchronously clear all outputs and return the FSM to IDLE, including mid-SEND.
- Cleared: req_o, ack_o, grant_o, flit_o, inj_cnt_o, id counter.
- Pointer goes to REQ_CNT-1.
- The in-flight flit is discarded and no ack_o is issued for it.
REQ-026 The first grant after reset release SHALL occur no earlier than the first rising edge with rst_i low.

Structure
REQ-027 br_data_t, br_svc_t and the ID_W default SHALL be taken from the shared BrLite package; the FSM state enum SHALL also live there.
REQ-028 A combinational round-robin priority picker SHALL be a separate sub-module, br_rr_picker (inputs: request vector and pointer; output: one-hot grant).

Verification
REQ-029 Single requester: req_i=0001, payload 0xAB, ack_i returned 2 cycles after req_o.
- flit_o.id=0 and req_o high 1 cycle after req_i.
- ack_o=0001 for one cycle; inj_cnt_o=1.
REQ-030 Contention: req_i=1111 held continuously.
- Grant order 0,1,2,3,0.
- ids 0..4; no ack_o overlap; injection spacing at least 3 cycles.
REQ-031 busy_i high for 10 cycles with req_i=0100: no req_o during busy; grant occurs 1 cycle after busy_i falls.
REQ-032 Id wrap: 33 consecutive injections with ID_W=5; the 33rd flit carries id=0.
REQ-033 Reset mid-SEND: assert rst_i while req_o high.
- req_o, grant_o low immediately; no ack_o.
- The next injection carries id=0 and goes to requester 0.
REQ-034 Requester drops req_i one cycle into SEND: injection completes with its latched flit and ack_o is still pulsed.
